ysyx_23060136_ifu_bht: RTL and testbench

- Branch history table with a branch target buffer, sitting in the IFU.
- Gives the fetch stage a taken/not-taken prediction and a target for the current fetch PC. The prediction travels down the pipe as EXU2_pre_take.
- Consumes the EXU2 branch resolution (pc, prediction-correct, prediction-wrong, actual target) to train 2-bit saturating counters and allocate entries.
- Direct-mapped and tagged; one lookup and one update per cycle.

---
 rtl/ysyx_23060136_bht_pkg.sv | 27 ++
 rtl/ysyx_23060136_bht_ctr_next.sv | 19 +
 rtl/ysyx_23060136_ifu_bht.sv | 116 +++++++++++
 tb/tb_ysyx_23060136_ifu_bht.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060136_bht_pkg.sv
// Shared types and constants for the IFU branch history table.
// Optional performance counters are enabled by YSYX_23060136_BHT_PERF_EN.
package ysyx_23060136_bht_pkg;

    localparam int unsigned BITS_W           = 32;
    localparam int unsigned BHT_ENTRIES_DFLT = 16;

    localparam logic [1:0] SNT     = 2'b00;
    localparam logic [1:0] WNT     = 2'b01;
    localparam logic [1:0] WT      = 2'b10;
    localparam logic [1:0] ST      = 2'b11;
    localparam logic [1:0] CTR_RST = WNT;

    typedef struct packed {
        logic              valid;
        logic [BITS_W-1:0] tag;
        logic [BITS_W-1:0] target;
        logic [1:0]        ctr;
    } bht_entry_t;

    // Tag is kept right-aligned in a full-width field; the unused upper bits stay zero.
    function automatic logic [BITS_W-1:0] bht_tag(input logic [BITS_W-1:0] pc,
                                                  input int unsigned       idx_w);
        return pc >> (idx_w + 2);
    endfunction

endpackage

// File: rtl/ysyx_23060136_bht_ctr_next.sv
// Two-bit saturating counter next-state: count up on taken, down otherwise.
module ysyx_23060136_bht_ctr_next
    import ysyx_23060136_bht_pkg::*;
(
    input  logic [1:0] ctr_i,
    input  logic       taken_i,
    output logic [1:0] ctr_n_o
);

    always_comb begin
        ctr_n_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != ST) ctr_n_o = ctr_i + 2'd1;
        end else begin
            if (ctr_i != SNT) ctr_n_o = ctr_i - 2'd1;
        end
    end

endmodule

// File: rtl/ysyx_23060136_ifu_bht.sv
// Direct-mapped, tagged BHT/BTB: combinational lookup for fetch, trained by EXU2 resolution.
// Define YSYX_23060136_BHT_PERF_EN to add the prediction correct/wrong counters.
module ysyx_23060136_ifu_bht
    import ysyx_23060136_bht_pkg::*;
#(
    parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS_W-1:0] IFU_pc,
    output logic              IFU_pre_take,
    output logic [BITS_W-1:0] IFU_pre_target,
    input  logic [BITS_W-1:0] BHT_pc,
    input  logic              BHT_pre_true,
    input  logic              BHT_pre_false,
    input  logic              BHT_pre_take,
    input  logic [BITS_W-1:0] BHT_target,
`ifdef YSYX_23060136_BHT_PERF_EN
    output logic [31:0]       perf_bht_correct,
    output logic [31:0]       perf_bht_wrong,
`endif
    input  logic              BHT_flush
);

    localparam int unsigned BHT_IDX_W = $clog2(BHT_ENTRIES);

    logic [BHT_ENTRIES-1:0] valid_q;
    logic [1:0]             ctr_q    [BHT_ENTRIES];
    logic [BITS_W-1:0]      tag_q    [BHT_ENTRIES];
    logic [BITS_W-1:0]      target_q [BHT_ENTRIES];

    logic [BHT_IDX_W-1:0] rd_idx;
    logic [BHT_IDX_W-1:0] wr_idx;
    logic                 rd_hit;
    logic                 wr_hit;
    logic                 upd;
    logic                 taken;
    logic                 we;
    logic [1:0]           ctr_n;
    bht_entry_t           entry_d;

    // Lookup path: reads current contents only, no bypass from a same-cycle update.
    assign rd_idx         = BHT_IDX_W'(IFU_pc >> 2);
    assign rd_hit         = valid_q[rd_idx] && (tag_q[rd_idx] == bht_tag(IFU_pc, BHT_IDX_W));
    assign IFU_pre_take   = rd_hit & ctr_q[rd_idx][1];
    assign IFU_pre_target = rd_hit ? target_q[rd_idx] : '0;

    // Both resolution flags high is treated as a misprediction.
    assign upd    = BHT_pre_true | BHT_pre_false;
    assign taken  = BHT_pre_take ^ BHT_pre_false;
    assign wr_idx = BHT_IDX_W'(BHT_pc >> 2);
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == bht_tag(BHT_pc, BHT_IDX_W));

    ysyx_23060136_bht_ctr_next u_ctr_next (
        .ctr_i   (ctr_q[wr_idx]),
        .taken_i (taken),
        .ctr_n_o (ctr_n)
    );

    always_comb begin
        we      = 1'b0;
        entry_d = '{valid: 1'b1, tag: bht_tag(BHT_pc, BHT_IDX_W),
                    target: target_q[wr_idx], ctr: ctr_n};
        if (upd && !BHT_flush) begin
            if (wr_hit) begin
                we = 1'b1;
                if (taken) entry_d.target = BHT_target;
            end else if (taken) begin
                we             = 1'b1;
                entry_d.target = BHT_target;
                entry_d.ctr    = WT;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(BHT_ENTRIES); i++) ctr_q[i] <= CTR_RST;
        end else if (BHT_flush) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_idx] <= entry_d.valid;
            ctr_q[wr_idx]   <= entry_d.ctr;
        end
    end

    // Tag/target storage has no reset; valid gates every use of it.
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            tag_q[wr_idx]    <= entry_d.tag;
            target_q[wr_idx] <= entry_d.target;
        end
    end

`ifdef YSYX_23060136_BHT_PERF_EN
    logic [31:0] perf_correct_q;
    logic [31:0] perf_wrong_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_correct_q <= '0;
            perf_wrong_q   <= '0;
        end else begin
            if (BHT_pre_true && !BHT_pre_false) perf_correct_q <= perf_correct_q + 32'd1;
            if (BHT_pre_false)                  perf_wrong_q   <= perf_wrong_q + 32'd1;
        end
    end

    assign perf_bht_correct = perf_correct_q;
    assign perf_bht_wrong   = perf_wrong_q;
`endif

    a_pre_excl: assert property (@(posedge clk) disable iff (rst) !(BHT_pre_true && BHT_pre_false));

endmodule

// File: tb/tb_ysyx_23060136_ifu_bht.sv
// Directed bench for the IFU BHT: allocation, hysteresis, aliasing, flush and async reset.
module tb_ysyx_23060136_ifu_bht;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] IFU_pc = '0;
    logic        IFU_pre_take;
    logic [31:0] IFU_pre_target;
    logic [31:0] BHT_pc = '0;
    logic        BHT_pre_true = 1'b0;
    logic        BHT_pre_false = 1'b0;
    logic        BHT_pre_take = 1'b0;
    logic [31:0] BHT_target = '0;
    logic        BHT_flush = 1'b0;
`ifdef YSYX_23060136_BHT_PERF_EN
    logic [31:0] perf_bht_correct;
    logic [31:0] perf_bht_wrong;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    ysyx_23060136_ifu_bht dut (
        .clk              (clk),
        .rst              (rst),
        .IFU_pc           (IFU_pc),
        .IFU_pre_take     (IFU_pre_take),
        .IFU_pre_target   (IFU_pre_target),
        .BHT_pc           (BHT_pc),
        .BHT_pre_true     (BHT_pre_true),
        .BHT_pre_false    (BHT_pre_false),
        .BHT_pre_take     (BHT_pre_take),
        .BHT_target       (BHT_target),
`ifdef YSYX_23060136_BHT_PERF_EN
        .perf_bht_correct (perf_bht_correct),
        .perf_bht_wrong   (perf_bht_wrong),
`endif
        .BHT_flush        (BHT_flush)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc,
                        input logic take, input logic [31:0] tgt);
        IFU_pc = pc;
        #1;
        check_eq({tag, ".take"}, 32'(IFU_pre_take), 32'(take));
        check_eq({tag, ".tgt"}, IFU_pre_target, tgt);
    endtask

    task automatic drive_upd(input logic [31:0] pc, input logic t, input logic f,
                             input logic take, input logic [31:0] tgt);
        BHT_pc        = pc;
        BHT_pre_true  = t;
        BHT_pre_false = f;
        BHT_pre_take  = take;
        BHT_target    = tgt;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        BHT_pre_true  = 1'b0;
        BHT_pre_false = 1'b0;
        BHT_flush     = 1'b0;
    endtask

    // Shorthands: taken / not-taken resolution of an earlier prediction.
    task automatic upd_t(input logic [31:0] pc, input logic [31:0] tgt);
        drive_upd(pc, 1'b1, 1'b0, 1'b1, tgt);
        step();
    endtask

    task automatic upd_nt(input logic [31:0] pc, input logic [31:0] tgt);
        drive_upd(pc, 1'b0, 1'b1, 1'b1, tgt);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        look("reset", 32'h8000_0000, 1'b0, 32'h0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Allocation via mispredicted not-taken; same-cycle lookup sees the old contents
        drive_upd(32'h8000_0010, 1'b0, 1'b1, 1'b0, 32'h8000_0100);
        look("alloc_same", 32'h8000_0010, 1'b0, 32'h0);
        step();
        look("alloc_next", 32'h8000_0010, 1'b1, 32'h8000_0100);

        // ctr 10 -> 11 -> 11 -> 11, last taken update moves the target
        upd_t(32'h8000_0010, 32'h8000_0100);
        look("tk1", 32'h8000_0010, 1'b1, 32'h8000_0100);
        upd_t(32'h8000_0010, 32'h8000_0100);
        look("tk2", 32'h8000_0010, 1'b1, 32'h8000_0100);
        upd_t(32'h8000_0010, 32'h8000_0200);
        look("tk3", 32'h8000_0010, 1'b1, 32'h8000_0200);

        // 11 -> 10 -> 01 -> 00 -> 00; not-taken updates leave target alone
        upd_nt(32'h8000_0010, 32'hDEAD_0000);
        look("nt1", 32'h8000_0010, 1'b1, 32'h8000_0200);
        upd_nt(32'h8000_0010, 32'hDEAD_0000);
        look("nt2", 32'h8000_0010, 1'b0, 32'h8000_0200);
        upd_nt(32'h8000_0010, 32'hDEAD_0000);
        upd_nt(32'h8000_0010, 32'hDEAD_0000);
        upd_nt(32'h8000_0010, 32'hDEAD_0000);
        look("nt_sat", 32'h8000_0010, 1'b0, 32'h8000_0200);
        upd_t(32'h8000_0010, 32'h8000_0200);
        look("sat_up1", 32'h8000_0010, 1'b0, 32'h8000_0200);
        upd_t(32'h8000_0010, 32'h8000_0200);
        look("sat_up2", 32'h8000_0010, 1'b1, 32'h8000_0200);

        // Alias eviction: 0x50 shares index 4 with 0x10
        upd_t(32'h8000_0050, 32'h8000_0300);
        look("alias_old", 32'h8000_0010, 1'b0, 32'h0);
        look("alias_new", 32'h8000_0050, 1'b1, 32'h8000_0300);
        upd_nt(32'h8000_0050, 32'h0);
        look("alias_ctr10", 32'h8000_0050, 1'b0, 32'h8000_0300);

        // Not-taken miss changes nothing
        upd_nt(32'h8000_0020, 32'h8000_0400);
        look("nt_miss", 32'h8000_0020, 1'b0, 32'h0);

        // Flush beats a same-cycle allocation; lookup that cycle still sees old entry
        upd_t(32'h8000_0030, 32'h8000_0500);
        drive_upd(32'h8000_0040, 1'b1, 1'b0, 1'b1, 32'h8000_0600);
        BHT_flush = 1'b1;
        look("flush_same", 32'h8000_0030, 1'b1, 32'h8000_0500);
        step();
        look("flush_30", 32'h8000_0030, 1'b0, 32'h0);
        look("flush_40", 32'h8000_0040, 1'b0, 32'h0);
        look("flush_50", 32'h8000_0050, 1'b0, 32'h0);

        // Asynchronous reset in the middle of an allocating update
        upd_t(32'h8000_0060, 32'h8000_0700);
        drive_upd(32'h8000_0070, 1'b1, 1'b0, 1'b1, 32'h8000_0800);
        look("pre_rst", 32'h8000_0060, 1'b1, 32'h8000_0700);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_async.take", 32'(IFU_pre_take), 32'h0);
        check_eq("rst_async.tgt", IFU_pre_target, 32'h0);
        step();
        rst = 1'b0;
        look("rst_70", 32'h8000_0070, 1'b0, 32'h0);
        look("rst_60", 32'h8000_0060, 1'b0, 32'h0);

`ifdef YSYX_23060136_BHT_PERF_EN
        check_eq("perf_rst_c", perf_bht_correct, 32'd0);
        check_eq("perf_rst_w", perf_bht_wrong, 32'd0);
        repeat (3) upd_t(32'h8000_0080, 32'h8000_0900);
        repeat (2) upd_nt(32'h8000_0080, 32'h0);
        check_eq("perf_c", perf_bht_correct, 32'd3);
        check_eq("perf_w", perf_bht_wrong, 32'd2);
        BHT_flush = 1'b1;
        step();
        check_eq("perf_flush_c", perf_bht_correct, 32'd3);
        check_eq("perf_flush_w", perf_bht_wrong, 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
